// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, opcode encodings and the sequencer
// state type. The original ADD..SRW encodings keep their values; XOR, SRA
// and MUL take the next free codes.
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB = OPW'(1);
  localparam logic [OPW-1:0] ALU_AND = OPW'(2);
  localparam logic [OPW-1:0] ALU_OR  = OPW'(3);
  localparam logic [OPW-1:0] ALU_ID  = OPW'(4);
  localparam logic [OPW-1:0] ALU_SLW = OPW'(5);
  localparam logic [OPW-1:0] ALU_SRW = OPW'(6);
  localparam logic [OPW-1:0] ALU_XOR = OPW'(7);
  localparam logic [OPW-1:0] ALU_SRA = OPW'(8);
  localparam logic [OPW-1:0] ALU_MUL = OPW'(9);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Handshake/data bundle between the register-read stage (master) and the
// sequential ALU (slave).
//   in_valid/in_ready : op transfer, in1/in2/alu_op/shift qualify it
//   out_valid/out_ready : result transfer, out/zero qualify it
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned OPW   = alu_pkg::OPW
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [OPW-1:0]   alu_op;
  logic [SHW-1:0]   shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output in_valid, in1, in2, alu_op, shift, out_ready,
    input  in_ready, out_valid, out, zero
  );

  modport slave (
    input  in_valid, in1, in2, alu_op, shift, out_ready,
    output in_ready, out_valid, out, zero
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock, fixed WIDTH iterations.
//   clk, rstn : clock, async active-low reset
//   start_i   : load operands and begin (ignored while busy is not expected)
//   a_i, b_i  : multiplicand, multiplier
//   done_o    : high during the final iteration cycle
//   prod_o    : low WIDTH bits of a_i*b_i, valid while done_o is high
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             last;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last  = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  // The final partial sum is exposed combinationally so the parent registers
  // it on the last iteration edge, keeping total latency at WIDTH+1.
  assign done_o = last;
  assign prod_o = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops produce a
// result the cycle after accept; MUL runs through alu_mul_seq and takes
// WIDTH+1 cycles. The result is held until the consumer takes it.
//   clk, rstn : clock, async active-low reset
//   bus       : alu_seq_if slave (op in, result out)
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input  logic     clk,
  input  logic     rstn,
  alu_seq_if.slave bus
);
  import alu_pkg::*;

  logic [WIDTH-1:0] a, b, res_c, mul_prod;
  logic [OPW-1:0]   op;
  logic [SHW-1:0]   sh;
  logic             accept, is_mul, mul_start, mul_done;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  assign a  = bus.in1;
  assign b  = bus.in2;
  assign op = bus.alu_op;
  assign sh = bus.shift;

  assign is_mul    = (op == ALU_MUL);
  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rstn   (rstn),
    .start_i(mul_start),
    .a_i    (a),
    .b_i    (b),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done)     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    res_c = '0;
    case (op)
      ALU_ADD: res_c = a + b;
      ALU_SUB: res_c = b - a;
      ALU_AND: res_c = a & b;
      ALU_OR:  res_c = a | b;
      ALU_XOR: res_c = a ^ b;
      ALU_ID:  res_c = b;
      ALU_SLW: res_c = a << sh;
      ALU_SRW: res_c = a >> sh;
      ALU_SRA: res_c = $unsigned($signed(a) >>> sh);
      default: res_c = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    zero_d = zero_q;
    if (accept && !is_mul) begin
      out_d  = res_c;
      zero_d = (res_c == '0);
    end else if ((state_q == ST_BUSY) && mul_done) begin
      out_d  = mul_prod;
      zero_d = (mul_prod == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): directed cases with literal expectations,
// then randomized traffic with random backpressure, all tracked by a
// transaction-level reference model checked every cycle.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference result from the opcode definitions, using plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] s);
    logic [63:0] p;
    logic [31:0] fill;
    case (op)
      ALU_ADD: return x + y;
      ALU_SUB: return y - x;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      ALU_ID:  return y;
      ALU_SLW: return x << s;
      ALU_SRW: return x >> s;
      ALU_SRA: begin
        fill = x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        return (x >> s) | fill;
      end
      ALU_MUL: begin
        p = {32'h0, x} * {32'h0, y};
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: one outstanding op at most; result appears 1 cycle (or W+1 for
  // MUL) after accept and stays until taken.
  initial begin
    int          cyc;
    bit          pending;
    int          rdy_cyc;
    logic [31:0] exp_val;
    bit          exp_ov;
    cyc = 0; pending = 0; rdy_cyc = 0; exp_val = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        chk("mon_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("mon_rst_out",       bus.out,                32'h0);
        chk("mon_rst_zero",      {31'h0, bus.zero},      32'h0);
        pending = 0;
      end else begin
        exp_ov = pending && (cyc >= rdy_cyc);
        chk("mon_in_ready",  {31'h0, bus.in_ready},  {31'h0, !pending});
        chk("mon_out_valid", {31'h0, bus.out_valid}, {31'h0, exp_ov});
        if (exp_ov) begin
          chk("mon_out",  bus.out,           exp_val);
          chk("mon_zero", {31'h0, bus.zero}, {31'h0, exp_val == 32'h0});
        end
        if (!pending && bus.in_valid) begin
          pending = 1;
          exp_val = model(bus.alu_op, bus.in1, bus.in2, bus.shift);
          rdy_cyc = cyc + ((bus.alu_op == ALU_MUL) ? W + 1 : 1);
        end else if (exp_ov && bus.out_ready) begin
          pending = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Offer one op, wait for accept, then wait for out_valid (bounded).
  // lat counts negedges after the accept edge up to the first out_valid.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, output logic [31:0] res, output logic z,
                       output int lat);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = op; bus.in1 = x; bus.in2 = y; bus.shift = s;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_wait", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 100);
    res = bus.out;
    z   = bus.zero;
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    int          lat;
    int          n;
    int          accepted;
    int          budget;
    bit          took;

    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.alu_op = '0; bus.shift = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out",       bus.out,                32'h0);
    chk("rst_zero",      {31'h0, bus.zero},      32'h0);

    bus.out_ready = 1'b1;
    do_op(ALU_ADD, 32'd5, 32'd12, 5'd0, r, z, lat);
    chk("add_out", r, 32'd17);
    chk("add_zero", {31'h0, z}, 32'h0);
    chk("add_lat", lat, 32'd1);
    @(negedge clk);
    chk("add_in_ready_after", {31'h0, bus.in_ready}, 32'h1);
    chk("add_out_valid_after", {31'h0, bus.out_valid}, 32'h0);

    do_op(ALU_SUB, 32'd12, 32'd5, 5'd0, r, z, lat);
    chk("sub_out", r, 32'hFFFF_FFF9);
    do_op(ALU_SUB, 32'd7, 32'd7, 5'd0, r, z, lat);
    chk("sub_eq_out", r, 32'h0);
    chk("sub_eq_zero", {31'h0, z}, 32'h1);
    do_op(ALU_SRA, 32'h8000_0000, 32'h0, 5'd4, r, z, lat);
    chk("sra_out", r, 32'hF800_0000);
    do_op(ALU_SRW, 32'h8000_0000, 32'h0, 5'd4, r, z, lat);
    chk("srw_out", r, 32'h0800_0000);
    do_op(ALU_SLW, 32'h1234_5678, 32'h0, 5'd0, r, z, lat);
    chk("slw0_out", r, 32'h1234_5678);
    do_op(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, r, z, lat);
    chk("xor_out", r, 32'hF00F_F00F);
    do_op(4'd15, 32'h1234_5678, 32'h1, 5'd3, r, z, lat);
    chk("undef_out", r, 32'h0);
    chk("undef_lat", lat, 32'd1);

    // MUL, with a competing ADD offered throughout BUSY.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = ALU_MUL;
    bus.in1 = 32'h0001_0001; bus.in2 = 32'h0001_0003; bus.shift = '0;
    @(negedge clk);
    chk("mul_accept", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk); #1;
    bus.alu_op = ALU_ADD; bus.in1 = 32'd1; bus.in2 = 32'd1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!bus.out_valid) chk("mul_busy_in_ready", {31'h0, bus.in_ready}, 32'h0);
    end while (!bus.out_valid && lat < 100);
    chk("mul_out", bus.out, 32'h0004_0003);
    chk("mul_lat", lat, 32'd33);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Backpressure on an AND result.
    bus.out_ready = 1'b0;
    do_op(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, r, z, lat);
    chk("and_out", r, 32'h0000_F000);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out", bus.out, 32'h0000_F000);
      chk("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'h0, bus.out_valid}, 32'h1);
    @(negedge clk);
    chk("bp_done_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("bp_done_ready", {31'h0, bus.in_ready}, 32'h1);

    // Reset at cycle 10 of a MUL.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_op = ALU_MUL; bus.in1 = 32'hDEAD_BEEF; bus.in2 = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mulrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("mulrst_out", bus.out, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    do_op(ALU_ADD, 32'd1, 32'd1, 5'd0, r, z, lat);
    chk("post_rst_add", r, 32'd2);
    chk("post_rst_lat", lat, 32'd1);

    // Randomized traffic; the producer holds each op until accepted.
    accepted = 0; budget = 0;
    while (accepted < 60 && budget < 6000) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) accepted++;
      @(posedge clk); #1;
      budget++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (took || !bus.in_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.in_valid = 1'b1;
          bus.alu_op   = 4'($urandom_range(0, 15));
          bus.in1      = $urandom;
          bus.in2      = ($urandom_range(0, 7) == 0) ? bus.in1 : $urandom;
          bus.shift    = 5'($urandom_range(0, 31));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("rand_accepted", accepted, 32'd60);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 200);
    chk("drain_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the core combinational ALU.
- Adds XOR, arithmetic right shift, an iterative multiplier, a zero flag, and valid/ready handshakes on both sides.
- Sits between the decode/register-read stage and writeback, so that multi-cycle ops stall the pipe cleanly.
- Single-cycle ops complete in one clock; MUL runs one bit per cycle.

Parameters:
- WIDTH, 32, datapath width in bits; must be >= 4.
- SHW, $clog2(WIDTH), shift-amount width.
- OPW, 4, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept an op.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- alu_op  input  OPW  opcode, from shared package.
- shift  input  SHW  shift amount.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.

Behaviour:
- Opcodes:
  - ADD: in1+in2.
  - SUB: in2-in1 (operand order fixed, matching the existing ALU).
  - AND, OR, XOR.
  - ID: in2.
  - SLW: in1<<shift.
  - SRW: logical in1>>shift.
  - SRA: arithmetic in1>>>shift.
  - MUL: low WIDTH bits of in1*in2, unsigned; signedness is irrelevant for the low half.
  - Any undefined opcode yields 0 with the normal 1-cycle latency.
- Arithmetic wraps modulo 2^WIDTH; no carry or overflow output.
- State machine IDLE, BUSY, DONE:
  - IDLE: in_ready=1, out_valid=0.
  - IDLE, in_valid=1, non-MUL op: compute and register out/zero, go to DONE. Latency is 1 cycle from accept to out_valid.
  - IDLE, in_valid=1, MUL: capture multiplicand=in1, multiplier=in2, acc=0, count=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. After WIDTH iterations, register out=acc and go to DONE. Total MUL latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1; out and zero are held stable until out_ready=1. On the handshake cycle go to IDLE. in_ready=0 in DONE; no result skid or bypass.
- Handshake rules:
  - Input transfer occurs on in_valid & in_ready at the rising edge.
  - Output transfer occurs on out_valid & out_ready.
  - in_valid while in_ready=0 is ignored; the producer must hold it.
  - out_ready while out_valid=0 has no effect.
  - out_ready held high in DONE gives a 1-op-per-2-cycles throughput for non-MUL ops.
- Shift amounts range 0..WIDTH-1; shift=0 returns in1 unchanged for SLW, SRW and SRA.
- zero is computed from the registered result and is valid whenever out_valid=1.
- Reset values (asynchronous assert, synchronous deassert handled upstream): state=IDLE, out=0, zero=0 (deliberately not 1), out_valid=0, in_ready=1 after the first clock post-reset; count, acc and operand registers cleared.
- Reset asserted mid-MUL or in DONE discards the operation; no partial result is ever presented.
- MUL early termination: none. Latency is fixed at WIDTH+1 regardless of operand values, so it is deterministic for the stall logic.

Decomposition:
- Shared package alu_pkg:
  - OPW and ALU_ADD..ALU_MUL opcode constants, extending the existing ALU_ADD/SUB/AND/OR/ID/SLW/SRW encodings with XOR, SRA, MUL. Existing encodings are unchanged.
  - State enum constants for IDLE/BUSY/DONE.
- Sub-module alu_mul_seq:
  - Shift-add iterative multiplier with start/done, parametrised on WIDTH.
  - Instantiated once; the top level holds the FSM, combinational ops and handshake.

Test Plan:
- Reset, then in1=5, in2=12, ADD with out_ready=1 -> out_valid one cycle after accept, out=17, zero=0, in_ready back to 1 the cycle after the handshake.
- SUB with in1=12, in2=5 (WIDTH=32) -> out=0xFFFFFFF9. SUB with in1=in2=7 -> out=0, zero=1.
- SRA with in1=0x80000000, shift=4 -> 0xF8000000. SRW with the same operands -> 0x08000000. SLW with shift=0 -> in1 unchanged.
- MUL with in1=0x0001_0001, in2=0x0001_0003 -> out=0x0004_0003 exactly 33 cycles after accept; in_ready=0 throughout BUSY; a new in_valid during BUSY is not accepted.
- Backpressure: hold out_ready=0 for 5 cycles after an AND (0xF0F0 & 0xFF00) -> out=0xF000 held stable with out_valid=1 and in_ready=0; release -> transfer on that edge.
- Assert rstn=0 at cycle 10 of a MUL -> out_valid=0 and out=0 immediately. After release, an ADD 1+1 returns 2 with the normal latency.
